// File: rtl/seq_normalizer.sv
// Multi-cycle left normalizer: shifts a word left one bit per clock until its MSB is set.
// Reports the shift count so a logical right shift by out_shift restores the original word.
module seq_normalizer #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_shift,
  output logic             out_zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work;
  logic [CNT_W-1:0] count;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (in_data == '0) ? DONE : SHIFT;
      SHIFT:   if (work[WIDTH-1]) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers are separate from the work register so they hold across the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work      <= '0;
      count     <= '0;
      out_data  <= '0;
      out_shift <= '0;
      out_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work  <= in_data;
          count <= '0;
          if (in_data == '0) begin
            out_data  <= '0;
            out_shift <= '0;
            out_zero  <= 1'b1;
          end
        end
        SHIFT: if (work[WIDTH-1]) begin
          out_data  <= work;
          out_shift <= count;
          out_zero  <= 1'b0;
        end else begin
          work  <= {work[WIDTH-2:0], 1'b0};
          count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_normalizer.sv
// Scoreboard bench for seq_normalizer: expected results queued at accept, compared at out_valid.
module tb_seq_normalizer;
  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_shift;
  logic          out_zero;

  seq_normalizer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_shift(out_shift), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic [CW-1:0] shift;
    logic          zero;
    int            lat;   // clock edges after the accept edge until out_valid is seen
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total    = 0;

  function automatic exp_t model(input logic [W-1:0] w);
    exp_t e;
    logic [W-1:0] t;
    int k;
    t = w;
    k = 0;
    e.zero = (w == '0);
    if (w == '0) begin
      e.data = '0; e.shift = '0; e.lat = 0;
    end else begin
      while (!t[W-1]) begin t = t << 1; k++; end
      e.data = t; e.shift = k[CW-1:0]; e.lat = k + 1;
    end
    return e;
  endfunction

  // Presents a word until accepted, then waits for out_valid; lat = -1 on timeout.
  task automatic send(input logic [W-1:0] w, output int lat);
    sb.push_back(model(w));
    in_data  = w;
    in_valid = 1'b1;
    lat      = -1;
    for (int i = 0; i < 50 && !in_ready; i++) begin @(posedge clk); #1; end
    if (!in_ready) begin in_valid = 1'b0; return; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 0; n <= W + 2; n++) begin
      if (out_valid) begin lat = n; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, out_data, out_shift, out_zero} !== {1'b1, 1'b0, {W{1'b0}}, {CW{1'b0}}, 1'b0}) begin
      $display("FAIL reset: rdy=%b vld=%b data=%h shift=%0d zero=%b, required rdy=1 vld=0 data=00 shift=0 zero=0",
               in_ready, out_valid, out_data, out_shift, out_zero);
    end else pass_cnt++;
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] words [4];
    exp_t e;
    int lat;
    words = '{8'b10101010, 8'b00010101, 8'b00000001, 8'b00000000};
    foreach (words[i]) begin
      send(words[i], lat);
      e = sb.pop_front();
      total++;
      if (lat !== e.lat || out_data !== e.data || out_shift !== e.shift || out_zero !== e.zero) begin
        $display("FAIL directed %h: data=%h shift=%0d zero=%b lat=%0d, required data=%h shift=%0d zero=%b lat=%0d",
                 words[i], out_data, out_shift, out_zero, lat, e.data, e.shift, e.zero, e.lat);
      end else pass_cnt++;
      handshake();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        $display("FAIL post_handshake %h: rdy=%b vld=%b, required rdy=1 vld=0", words[i], in_ready, out_valid);
      end else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int lat;
    send(8'b00010101, lat);
    e = sb.pop_front();
    in_data  = 8'b01000000;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== e.data || out_shift !== e.shift || out_zero !== e.zero) begin
        $display("FAIL backpressure cyc%0d: vld=%b rdy=%b data=%h shift=%0d, required vld=1 rdy=0 data=%h shift=%0d",
                 c, out_valid, in_ready, out_data, out_shift, e.data, e.shift);
      end else pass_cnt++;
    end
    handshake();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL bp_release: rdy=%b vld=%b, required rdy=1 vld=0", in_ready, out_valid);
    end else pass_cnt++;
    send(8'b01000000, lat);
    e = sb.pop_front();
    total++;
    if (lat !== e.lat || out_data !== e.data || out_shift !== e.shift || out_zero !== e.zero) begin
      $display("FAIL bp_second: data=%h shift=%0d lat=%0d, required data=%h shift=%0d lat=%0d",
               out_data, out_shift, lat, e.data, e.shift, e.lat);
    end else pass_cnt++;
    handshake();
  endtask

  task automatic test_reset_mid_shift();
    exp_t e;
    int lat;
    in_data  = 8'b00000100;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || out_shift !== '0 || out_zero !== 1'b0) begin
      $display("FAIL mid_reset: vld=%b rdy=%b data=%h shift=%0d, required vld=0 rdy=1 data=00 shift=0",
               out_valid, in_ready, out_data, out_shift);
    end else pass_cnt++;
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'b01000000, lat);
    e = sb.pop_front();
    total++;
    if (lat !== 2 || out_data !== 8'b10000000 || out_shift !== 1 || out_zero !== e.zero) begin
      $display("FAIL after_reset: data=%h shift=%0d lat=%0d, required data=80 shift=1 lat=2",
               out_data, out_shift, lat);
    end else pass_cnt++;
    handshake();
  endtask

  task automatic test_sweep();
    logic [W-1:0] w;
    logic [W-1:0] restored;
    exp_t e;
    int lat;
    for (int i = 0; i < 40; i++) begin
      w = W'($urandom_range(1, (1 << W) - 1));
      send(w, lat);
      e = sb.pop_front();
      restored = out_data >> out_shift;
      total++;
      if (restored !== w || lat !== e.lat || out_data !== e.data || out_zero !== 1'b0) begin
        $display("FAIL sweep %h: data=%h shift=%0d restored=%h lat=%0d, required data=%h restored=%h lat=%0d",
                 w, out_data, out_shift, restored, lat, e.data, w, e.lat);
      end else pass_cnt++;
      for (int d = $urandom_range(0, 2); d > 0; d--) begin @(posedge clk); #1; end
      handshake();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_shift();
    test_sweep();
    total++;
    if (sb.size() !== 0) $display("FAIL scoreboard: %0d entries left, required 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
